// File: rtl/shift_deser16.sv
// rtl/shift_deser16.sv - serial-to-parallel receiver with one-word valid/ready holding register
module shift_deser16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             frame_start,
    input  logic             lsb_first,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Count value held while the final bit of a word is being accepted.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             order_q, order_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             bit_accept;
    logic             restart;
    logic             last_bit;
    logic             hold_free;
    logic             order_eff;
    logic [WIDTH-1:0] sr_base;
    logic [WIDTH-1:0] sr_shifted;

    assign bit_accept = enable & serial_valid;
    // A frame-start bit always begins a new frame, in IDLE or mid-frame.
    assign restart    = bit_accept & frame_start;
    assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    // The holding register can take a word if empty or being drained this edge.
    assign hold_free  = ~valid_q | data_ready;

    // Shift the incoming bit into either end; a restart begins from an empty register.
    always_comb begin
        sr_base   = restart ? '0 : sr_q;
        order_eff = restart ? lsb_first : order_q;
        if (order_eff) begin
            sr_shifted = {serial_in, sr_base[WIDTH-1:1]};
        end else begin
            sr_shifted = {sr_base[WIDTH-2:0], serial_in};
        end
    end

    // Frame FSM, bit counter, holding register and overrun flag next-state logic.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        order_d   = order_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        // Consumer drain; a word completing this same edge may reload below.
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        if (restart) begin
            state_d = SHIFT;
            order_d = lsb_first;
            sr_d    = sr_shifted;
            cnt_d   = CNT_W'(1);
        end else if (bit_accept && state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
                sr_d    = '0;
                cnt_d   = '0;
                if (hold_free) begin
                    data_d  = sr_shifted;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                sr_d  = sr_shifted;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            order_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            order_q   <= order_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = (state_q == SHIFT);
    assign bit_count  = cnt_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_shift_deser16.sv
// tb/tb_shift_deser16.sv - self-checking bench for shift_deser16
module tb_shift_deser16;

    localparam int W  = 16;
    localparam int CW = 5;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          serial_in;
    logic          serial_valid;
    logic          frame_start;
    logic          lsb_first;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic          data_ready;
    logic          busy;
    logic [CW-1:0] bit_count;
    logic          overrun;

    shift_deser16 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .lsb_first    (lsb_first),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .busy         (busy),
        .bit_count    (bit_count),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int dut_valid_cycles = 0;

    // Reference model: bits of the current frame kept as a list, word built arithmetically.
    bit           m_valid;
    bit           m_overrun;
    bit           m_in_frame;
    bit           m_order;
    logic [W-1:0] m_data;
    bit           m_bits[$];

    typedef struct {
        logic [15:0] stream;
        bit          lsb;
        logic [15:0] exp_word;
    } vec_t;
    vec_t tbl[6];

    task automatic model_reset();
        m_valid    = 0;
        m_overrun  = 0;
        m_in_frame = 0;
        m_order    = 0;
        m_data     = '0;
        m_bits.delete();
    endtask

    task automatic model_step();
        bit           free;
        logic [W-1:0] word;
        free = !m_valid || data_ready;
        if (m_valid && data_ready) m_valid = 0;
        if (enable && serial_valid) begin
            if (frame_start) begin
                m_bits.delete();
                m_bits.push_back(serial_in);
                m_order    = lsb_first;
                m_in_frame = 1;
            end else if (m_in_frame) begin
                m_bits.push_back(serial_in);
                if (m_bits.size() == W) begin
                    word = '0;
                    for (int i = 0; i < W; i++) begin
                        if (m_order) word[i] = m_bits[i];
                        else         word[W-1-i] = m_bits[i];
                    end
                    m_bits.delete();
                    m_in_frame = 0;
                    if (free) begin
                        m_data  = word;
                        m_valid = 1;
                    end else begin
                        m_overrun = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs(string tag);
        n_vec++;
        if (data_valid !== m_valid || data_out !== m_data || busy !== m_in_frame ||
            bit_count !== CW'(m_bits.size()) || overrun !== m_overrun) begin
            n_err++;
            $display("FAIL %s: got valid=%0b data=%h busy=%0b cnt=%0d ovr=%0b, want valid=%0b data=%h busy=%0b cnt=%0d ovr=%0b",
                     tag, data_valid, data_out, busy, bit_count, overrun,
                     m_valid, m_data, m_in_frame, m_bits.size(), m_overrun);
        end
    endtask

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic step(bit en, bit sv, bit si, bit fs, bit lsb, bit rdy, string tag);
        enable       = en;
        serial_valid = sv;
        serial_in    = si;
        frame_start  = fs;
        lsb_first    = lsb;
        data_ready   = rdy;
        model_step();
        @(posedge clk);
        #1;
        if (data_valid) dut_valid_cycles++;
        check_outputs(tag);
    endtask

    task automatic send_frame(logic [15:0] w, bit lsb, bit rdy, bit rdy_last, string tag);
        for (int i = 0; i < W; i++) begin
            step(1, 1, w[15-i], i == 0, lsb, (i == W-1) ? rdy_last : rdy, tag);
        end
    endtask

    task automatic async_reset(string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_val({tag, "_valid"}, 32'(data_valid), 32'd0);
        check_val({tag, "_data"},  32'(data_out),   32'd0);
        check_val({tag, "_busy"},  32'(busy),       32'd0);
        check_val({tag, "_cnt"},   32'(bit_count),  32'd0);
        check_val({tag, "_ovr"},   32'(overrun),    32'd0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16'hA5C3, 1'b0, 16'hA5C3};
        tbl[1] = '{16'hA5C3, 1'b1, 16'hC3A5};
        tbl[2] = '{16'h1234, 1'b0, 16'h1234};
        tbl[3] = '{16'hBEEF, 1'b0, 16'hBEEF};
        tbl[4] = '{16'h0001, 1'b1, 16'h8000};
        tbl[5] = '{16'hF0F0, 1'b1, 16'h0F0F};

        reset = 1'b1;
        enable = 0; serial_valid = 0; serial_in = 0; frame_start = 0; lsb_first = 0; data_ready = 0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b0;

        // Table of whole frames: word appears one cycle after the last bit, then drains.
        foreach (tbl[k]) begin
            send_frame(tbl[k].stream, tbl[k].lsb, 0, 0, "tbl_frame");
            check_val("tbl_valid", 32'(data_valid), 32'd1);
            check_val("tbl_data", 32'(data_out), 32'(tbl[k].exp_word));
            step(1, 0, 0, 0, 0, 1, "tbl_drain");
            check_val("tbl_drained", 32'(data_valid), 32'd0);
        end

        // lsb_first only matters on the frame-start bit.
        for (int i = 0; i < W; i++) begin
            logic [15:0] s;
            s = 16'hA5C3;
            step(1, 1, s[15-i], i == 0, (i == 0) ? 1'b1 : i[0], 0, "lsb_toggle");
        end
        check_val("lsb_toggle_data", 32'(data_out), 32'h0000C3A5);
        step(1, 0, 0, 0, 0, 1, "lsb_toggle_drain");

        // Gaps in serial_valid and enable low mid-frame.
        for (int i = 0; i < W; i++) begin
            logic [15:0] s;
            s = 16'hA5C3;
            if (i == 8) begin
                for (int g = 0; g < 3; g++) step(1, 0, 1, 0, 0, 0, "gap_sv");
                check_val("gap_sv_cnt", 32'(bit_count), 32'd8);
                for (int g = 0; g < 2; g++) step(0, 1, 1, 1, 1, 0, "gap_en");
                check_val("gap_en_cnt", 32'(bit_count), 32'd8);
            end
            step(1, 1, s[15-i], i == 0, 0, 0, "gap_frame");
        end
        check_val("gap_data", 32'(data_out), 32'h0000A5C3);
        step(1, 0, 0, 0, 0, 1, "gap_drain");

        // Restart after 7 bits.
        dut_valid_cycles = 0;
        for (int i = 0; i < 7; i++) step(1, 1, 1'(i), i == 0, 0, 1, "restart_part");
        send_frame(16'h1234, 0, 1, 1, "restart_frame");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, "restart_idle");
        check_val("restart_data", 32'(data_out), 32'h00001234);
        check_val("restart_ovr", 32'(overrun), 32'd0);
        check_val("restart_pulses", 32'(dut_valid_cycles), 32'd1);

        // Overrun: second word dropped while first is held.
        send_frame(16'h00FF, 0, 0, 0, "ovr_first");
        send_frame(16'hFF00, 0, 0, 0, "ovr_second");
        check_val("ovr_data", 32'(data_out), 32'h000000FF);
        check_val("ovr_flag", 32'(overrun), 32'd1);
        check_val("ovr_valid", 32'(data_valid), 32'd1);
        async_reset("ovr_rst");

        // Simultaneous drain and load on the completion edge.
        send_frame(16'h00FF, 0, 0, 0, "sim_first");
        send_frame(16'hFF00, 0, 0, 1, "sim_second");
        check_val("sim_data", 32'(data_out), 32'h0000FF00);
        check_val("sim_valid", 32'(data_valid), 32'd1);
        check_val("sim_ovr", 32'(overrun), 32'd0);
        step(1, 0, 0, 0, 0, 1, "sim_drain");

        // Reset mid-frame and while a word is held.
        for (int i = 0; i < 9; i++) step(1, 1, 1, i == 0, 0, 0, "mid_part");
        check_val("mid_cnt", 32'(bit_count), 32'd9);
        async_reset("mid_rst");
        send_frame(16'h5A5A, 0, 0, 0, "held_frame");
        async_reset("held_rst");
        send_frame(16'hBEEF, 0, 0, 0, "beef");
        check_val("beef_data", 32'(data_out), 32'h0000BEEF);
        check_val("beef_valid", 32'(data_valid), 32'd1);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 1'($urandom),
                 $urandom_range(0, 29) == 0, 1'($urandom), 1'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
